// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the RS-232 receiver / CPU I/O decode and the receive FIFO.
// The slave side is the FIFO itself; the master side is whoever drives the
// receiver handshake and the CPU pop/clear strobes.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_data;
    logic                rx_rdy;
    logic                rx_done;
    logic                pop;
    logic                ovr_clr;
    logic [7:0]          data_out;
    logic                nempty;
    logic [DEPTH_LOG2:0] level;
    logic                ovr;
    logic [7:0]          drop_cnt;

    modport master (
        output rx_data, rx_rdy, pop, ovr_clr,
        input  rx_done, data_out, nempty, level, ovr, drop_cnt
    );

    modport slave (
        input  rx_data, rx_rdy, pop, ovr_clr,
        output rx_done, data_out, nempty, level, ovr, drop_cnt
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the CPU I/O bus.
// Every byte the receiver offers is acknowledged with a one-cycle rx_done
// pulse; it is queued if there is room, otherwise dropped and counted.
// The CPU reads the head through data_out and removes it with pop.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic           clk,
    input logic           rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  rx_done_q;
    logic                  rx_done_d;
    logic                  capture;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_q;

    logic                  pop_eff;
    logic                  accept;
    logic                  drop;

    logic                  ovr_q;
    logic [7:0]            drop_cnt_q;

    // Intake state register; reset mid-ACK drops rx_done at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_done_q <= rx_done_d;
        end
    end

    // Intake next-state: take a byte in IDLE, then spend one cycle in ACK
    // ignoring rx_rdy so the receiver has time to drop it.
    always_comb begin
        state_d   = state_q;
        rx_done_d = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_rdy) begin
                    capture   = 1'b1;
                    rx_done_d = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Push/pop qualification; a full FIFO still accepts when a pop frees a slot.
    always_comb begin
        pop_eff = bus.pop && (level_q != '0);
        accept  = capture && ((level_q != FULL_LEVEL) || bus.pop);
        drop    = capture && !accept;
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({accept, pop_eff})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Overrun flag and saturating drop counter; a drop beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q      <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else if (drop) begin
            ovr_q <= 1'b1;
            if (bus.ovr_clr) begin
                drop_cnt_q <= 8'h01;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'h01;
            end
        end else if (bus.ovr_clr) begin
            ovr_q      <= 1'b0;
            drop_cnt_q <= 8'h00;
        end
    end

    // Head byte is decoded straight from the array so the CPU can read it in
    // the same cycle it pops; an empty FIFO reads as zero.
    always_comb begin
        bus.data_out = (level_q != '0) ? mem[rd_ptr] : 8'h00;
    end

    assign bus.rx_done  = rx_done_q;
    assign bus.nempty   = (level_q != '0);
    assign bus.level    = level_q;
    assign bus.ovr      = ovr_q;
    assign bus.drop_cnt = drop_cnt_q;
endmodule
